// File: rtl/mips_pkg.sv
// mips_pkg: opcode constants and fetch-stage types shared across the MIPS datapath.
package mips_pkg;
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [31:0] NOP_INSTR = 32'h0;
    typedef enum logic [1:0] {FS_IDLE, FS_RUN, FS_WAIT, FS_FLUSH} fetch_state_e;
endpackage

// File: rtl/ifetch_hold_buf.sv
// ifetch_hold_buf: one-entry skid slot for a fetch response that IF/ID cannot take yet.
module ifetch_hold_buf (
    input  logic        clk,
    input  logic        rst,
    input  logic        clr_i,
    input  logic        load_i,
    input  logic        drain_i,
    input  logic [31:0] instr_i,
    input  logic [31:0] pc4_i,
    output logic        full_o,
    output logic [31:0] instr_o,
    output logic [31:0] pc4_o
);
    logic        full_q;
    logic [31:0] instr_q, pc4_q;
    always_ff @(posedge clk) begin
        if (rst || clr_i) full_q <= 1'b0;
        else if (load_i) full_q <= 1'b1;
        else if (drain_i) full_q <= 1'b0;
        if (rst) begin
            instr_q <= 32'h0;
            pc4_q   <= 32'h0;
        end else if (load_i) begin
            instr_q <= instr_i;
            pc4_q   <= pc4_i;
        end
    end
    assign full_o  = full_q;
    assign instr_o = instr_q;
    assign pc4_o   = pc4_q;
endmodule

// File: rtl/ifetch_stage.sv
// ifetch_stage: PC, single-outstanding instruction fetch, hold buffer and redirect flush feeding IF/ID.
module ifetch_stage
    import mips_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_valid,
    input  logic [31:0] imem_rdata,
    input  logic        stall,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        ifid_valid,
    output logic [31:0] ifid_instr,
    output logic [31:0] ifid_pc4,
    output logic [5:0]  ifid_opcode
);
    fetch_state_e state_q, state_d;
    logic [31:0]  pc_q, pc_d, instr_q, instr_d, pc4_q, pc4_d;
    logic         valid_q, valid_d;
    logic         hb_full;
    logic [31:0]  hb_instr, hb_pc4;
    logic         in_flight, resp, drain, hb_load, ifid_load, hb_busy;
    assign in_flight = (state_q == FS_WAIT) || (state_q == FS_FLUSH);
    assign resp      = imem_valid && (state_q == FS_WAIT) && !redirect_valid;
    assign drain     = hb_full && !stall;
    assign hb_load   = resp && (drain || (valid_q && stall));
    assign ifid_load = drain || (resp && !hb_load);
    // a request is only safe if the hold buffer will still be empty after this edge
    assign hb_busy   = hb_load || (hb_full && stall);
    assign imem_req  = !rst && !redirect_valid && !hb_busy &&
                       ((state_q == FS_RUN) || (in_flight && imem_valid));
    always_comb begin
        state_d = state_q;
        if (state_q == FS_IDLE) state_d = FS_RUN;
        else if (redirect_valid) state_d = (in_flight && !imem_valid) ? FS_FLUSH : FS_RUN;
        else if (imem_req) state_d = FS_WAIT;
        else if (in_flight && imem_valid) state_d = FS_RUN;
    end
    // pc already points one word past the outstanding fetch, so it doubles as that fetch's pc4
    assign pc_d    = redirect_valid ? (redirect_pc & ~32'h3) : imem_req ? pc_q + 32'd4 : pc_q;
    assign valid_d = !redirect_valid && (ifid_load || (stall && valid_q));
    assign instr_d = ifid_load ? (drain ? hb_instr : imem_rdata) : instr_q;
    assign pc4_d   = ifid_load ? (drain ? hb_pc4 : pc_q) : pc4_q;
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= FS_IDLE;
            pc_q    <= RESET_PC;
            valid_q <= 1'b0;
            instr_q <= NOP_INSTR;
            pc4_q   <= 32'h0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            valid_q <= valid_d;
            instr_q <= instr_d;
            pc4_q   <= pc4_d;
        end
    end
    ifetch_hold_buf u_hold (
        .clk     (clk),
        .rst     (rst),
        .clr_i   (redirect_valid),
        .load_i  (hb_load),
        .drain_i (drain),
        .instr_i (imem_rdata),
        .pc4_i   (pc_q),
        .full_o  (hb_full),
        .instr_o (hb_instr),
        .pc4_o   (hb_pc4)
    );
    assign imem_addr   = pc_q;
    assign ifid_valid  = valid_q;
    assign ifid_instr  = instr_q;
    assign ifid_pc4    = pc4_q;
    assign ifid_opcode = instr_q[31:26];
endmodule

// File: tb/tb_ifetch_stage.sv
// tb_ifetch_stage: random and directed fetch traffic checked against a queue-based transaction model.
module tb_ifetch_stage;
    import mips_pkg::*;
    logic        clk = 1'b0, rst = 1'b1;
    logic        imem_req, imem_valid = 1'b0, stall = 1'b0, redirect_valid = 1'b0;
    logic [31:0] imem_addr, imem_rdata = 32'h0, redirect_pc = 32'h0;
    logic        ifid_valid;
    logic [31:0] ifid_instr, ifid_pc4;
    logic [5:0]  ifid_opcode;
    ifetch_stage dut (
        .clk            (clk),
        .rst            (rst),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_valid     (imem_valid),
        .imem_rdata     (imem_rdata),
        .stall          (stall),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .ifid_valid     (ifid_valid),
        .ifid_instr     (ifid_instr),
        .ifid_pc4       (ifid_pc4),
        .ifid_opcode    (ifid_opcode)
    );
    always #5 clk = ~clk;
    typedef struct {logic [31:0] instr; logic [31:0] pc4;} ent_t;
    typedef struct {int due; logic [31:0] data;} rsp_t;
    ent_t        q[$];
    rsp_t        mq[$];
    int          checks = 0, errors = 0, lat = 1, cyc = 0;
    bit          m_started, m_out, m_drop, last_req;
    logic [31:0] m_pc, m_oaddr;
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s cyc=%0d got=%h exp=%h", tag, cyc, got, exp);
        end
    endtask
    function automatic logic [31:0] mem(input logic [31:0] a);
        return (a == 32'h0) ? 32'h8C22_0004 : (a * 32'h0100_0193) ^ 32'h5A5A_1234;
    endfunction
    // one clock: drive inputs, predict the request, then advance the model and compare IF/ID
    task automatic step(input bit st, input bit rv, input logic [31:0] rpc, input bit r);
        int sz, sz_after;
        bit exp_req, resp;
        ent_t e;
        rsp_t m;
        stall = st; redirect_valid = rv; redirect_pc = rpc; rst = r;
        if (mq.size() > 0 && mq[0].due <= cyc) begin
            imem_valid = 1'b1; imem_rdata = mq[0].data; void'(mq.pop_front());
        end else begin
            imem_valid = 1'b0; imem_rdata = $urandom;
        end
        @(negedge clk);
        sz = q.size();
        resp = imem_valid && m_out;
        sz_after = sz - ((!st && sz > 0) ? 1 : 0) + ((resp && !m_drop) ? 1 : 0);
        exp_req = !r && m_started && !rv && (!m_out || imem_valid) && sz_after < 2;
        check("imem_req", {31'h0, imem_req}, {31'h0, exp_req});
        check("imem_addr", imem_addr, m_pc);
        last_req = imem_req;
        if (imem_req) begin
            m.due = cyc + lat; m.data = mem(imem_addr); mq.push_back(m);
        end
        @(posedge clk);
        if (r) begin
            m_started = 0; m_out = 0; m_drop = 0; m_pc = 32'h0; q.delete();
        end else begin
            m_started = 1;
            if (rv) begin
                q.delete();
                m_pc = rpc & ~32'h3;
                if (m_out && !imem_valid) m_drop = 1;
                else begin m_out = 0; m_drop = 0; end
            end else begin
                if (!st && q.size() > 0) void'(q.pop_front());
                if (resp && !m_drop) begin
                    e.instr = mem(m_oaddr); e.pc4 = m_oaddr + 32'd4; q.push_back(e);
                end
                if (resp) begin m_out = 0; m_drop = 0; end
                if (exp_req) begin m_out = 1; m_oaddr = m_pc; m_pc = m_pc + 32'd4; end
            end
        end
        #1;
        check("ifid_valid", {31'h0, ifid_valid}, {31'h0, q.size() > 0});
        if (r) begin
            check("rst_instr", ifid_instr, NOP_INSTR);
            check("rst_pc4", ifid_pc4, 32'h0);
            check("rst_opcode", {26'h0, ifid_opcode}, 32'h0);
        end else if (q.size() > 0) begin
            check("ifid_instr", ifid_instr, q[0].instr);
            check("ifid_pc4", ifid_pc4, q[0].pc4);
            check("ifid_opcode", {26'h0, ifid_opcode}, {26'h0, q[0].instr[31:26]});
        end
        cyc++;
    endtask
    initial begin
        bit found;
        @(posedge clk); #1;
        repeat (2) step(0, 0, 32'h0, 1);
        lat = 1;
        repeat (3) step(0, 0, 32'h0, 0);
        check("first_opcode_lw", {26'h0, ifid_opcode}, {26'h0, OP_LW});
        repeat (5) step(0, 0, 32'h0, 0);
        repeat (3) step(1, 0, 32'h0, 0);
        repeat (6) step(0, 0, 32'h0, 0);
        lat = 3;
        repeat (5) step(0, 0, 32'h0, 0);
        step(0, 1, 32'h0000_0043, 0);
        repeat (8) step(0, 0, 32'h0, 0);
        lat = 1;
        repeat (4) step(0, 0, 32'h0, 0);
        step(0, 1, 32'h0000_0100, 0);
        repeat (5) step(0, 0, 32'h0, 0);
        step(0, 1, 32'hFFFF_FFFC, 0);
        repeat (6) step(0, 0, 32'h0, 0);
        lat = 3;
        found = 0;
        for (int i = 0; i < 10 && !found; i++) begin
            step(0, 0, 32'h0, 0);
            found = last_req;
        end
        check("wait_reached", {31'h0, found}, 32'h1);
        step(0, 0, 32'h0, 1);
        repeat (8) step(0, 0, 32'h0, 0);
        for (int p = 1; p <= 3; p++) begin
            lat = p;
            step(0, 0, 32'h0, 1);
            for (int i = 0; i < 300; i++)
                step($urandom_range(0, 99) < 30, $urandom_range(0, 99) < 5, $urandom, 0);
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
